// File: rtl/l_gates_checker.sv
// Self-checking sequencer for the 2-input logic-gate block: sweeps {a,b}, checks y_i.
// Optional LGC_ERR_ACCUM_EN adds err_bits, a sticky OR of all mismatch masks in a run.
module l_gates_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic [6:0]       y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_fail_vec,
`ifdef LGC_ERR_ACCUM_EN
    output logic [6:0]       err_bits,
`endif
    output logic [6:0]       first_fail_mask
);

    localparam int unsigned CntW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned LoopW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [CntW-1:0]  CntLoad  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [LoopW-1:0] LoopLast = LoopW'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ErrOne   = ERR_W'(1);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [LoopW-1:0] loop_q, loop_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       ffv_q, ffv_d;
    logic [6:0]       ffm_q, ffm_d;
    logic             pass_q, pass_d;
    logic [6:0]       golden;
    logic [6:0]       mismatch;

    always_comb begin
        unique case (vec_q)
            2'b00:   golden = 7'h5C;
            2'b01:   golden = 7'h2E;
            2'b10:   golden = 7'h2A;
            default: golden = 7'h43;
        endcase
    end

    assign mismatch = y_i ^ golden;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        loop_d  = loop_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffm_d   = ffm_q;
        pass_d  = pass_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    vec_d   = 2'b00;
                    loop_d  = '0;
                    cnt_d   = CntLoad;
                    err_d   = '0;
                    ffv_d   = 2'b00;
                    ffm_d   = 7'h00;
                    pass_d  = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCheck: begin
                if (mismatch != 7'h00) begin
                    if (err_q != '1) begin
                        err_d = err_q + ErrOne;
                    end
                    // Count is cleared at start and saturates, so zero marks the first miss.
                    if (err_q == '0) begin
                        ffv_d = vec_q;
                        ffm_d = mismatch;
                    end
                end
                if (vec_q == 2'b11 && loop_q == LoopLast) begin
                    state_d = StDone;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = StSettle;
                    cnt_d   = CntLoad;
                    vec_d   = vec_q + 2'd1;
                    if (vec_q == 2'b11) begin
                        loop_d = loop_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= 2'b00;
            cnt_q   <= '0;
            loop_q  <= '0;
            err_q   <= '0;
            ffv_q   <= 2'b00;
            ffm_q   <= 7'h00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            loop_q  <= loop_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffm_q   <= ffm_d;
            pass_q  <= pass_d;
        end
    end

`ifdef LGC_ERR_ACCUM_EN
    logic [6:0] bits_q, bits_d;

    always_comb begin
        bits_d = bits_q;
        if (state_q == StIdle && start) begin
            bits_d = 7'h00;
        end else if (state_q == StCheck) begin
            bits_d = bits_q | mismatch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q <= 7'h00;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign err_bits = bits_q;
`endif

    assign a_o             = vec_q[1];
    assign b_o             = vec_q[0];
    assign busy            = (state_q == StSettle) || (state_q == StCheck);
    assign done            = (state_q == StDone);
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_l_gates_checker.sv
// Bench for l_gates_checker: run-schedule reference model plus literal result checks.
module tb_l_gates_checker;

    localparam int SA   = 2;
    localparam int LA   = 1;
    localparam int TotA = 4 * LA * (SA + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [6:0] and_a, flip_a;
    logic       tie_b;

    logic       a_a, b_a, busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [1:0] ffv_a;
    logic [6:0] ffm_a, y_a;
    logic       a_b, b_b, busy_b, done_b, pass_b;
    logic [7:0] err_b;
    logic [1:0] ffv_b;
    logic [6:0] ffm_b, y_b;
`ifdef LGC_ERR_ACCUM_EN
    logic [6:0] bits_a, bits_b;
`endif

    int checks = 0;
    int errors = 0;
    int busy_seen, done_seen;

    function automatic logic [6:0] gate(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    assign y_a = (gate(a_a, b_a) & and_a) ^ flip_a;
    assign y_b = tie_b ? 7'h00 : gate(a_b, b_b);

    l_gates_checker #(.SETTLE_CYCLES(SA), .LOOPS(LA), .ERR_W(8)) u_dut_a (
        .clk             (clk),
        .rst             (rst),
        .start           (start_a),
        .a_o             (a_a),
        .b_o             (b_a),
        .y_i             (y_a),
        .busy            (busy_a),
        .done            (done_a),
        .pass            (pass_a),
        .err_cnt         (err_a),
        .first_fail_vec  (ffv_a),
`ifdef LGC_ERR_ACCUM_EN
        .err_bits        (bits_a),
`endif
        .first_fail_mask (ffm_a)
    );

    l_gates_checker #(.SETTLE_CYCLES(1), .LOOPS(100), .ERR_W(8)) u_dut_b (
        .clk             (clk),
        .rst             (rst),
        .start           (start_b),
        .a_o             (a_b),
        .b_o             (b_b),
        .y_i             (y_b),
        .busy            (busy_b),
        .done            (done_b),
        .pass            (pass_b),
        .err_cnt         (err_b),
        .first_fail_vec  (ffv_b),
`ifdef LGC_ERR_ACCUM_EN
        .err_bits        (bits_b),
`endif
        .first_fail_mask (ffm_b)
    );

    // Reference model: a run is a cycle index k; busy for k < TotA, done at k == TotA.
    logic       m_run;
    int         m_k;
    logic [1:0] m_hold;
    logic [7:0] m_err;
    logic [1:0] m_ffv;
    logic [6:0] m_ffm, m_bits;
    logic       m_pass;
    logic [1:0] exp_vec;
    logic [6:0] m_mm;
    logic       exp_busy, exp_done;

    assign exp_busy = m_run && (m_k < TotA);
    assign exp_done = m_run && (m_k == TotA);
    assign exp_vec  = exp_busy ? 2'((m_k / (SA + 1)) % 4) : m_hold;
    assign m_mm     = y_a ^ gate(exp_vec[1], exp_vec[0]);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_k    <= 0;
            m_hold <= 2'b00;
            m_err  <= 8'h00;
            m_ffv  <= 2'b00;
            m_ffm  <= 7'h00;
            m_bits <= 7'h00;
            m_pass <= 1'b0;
        end else if (!m_run) begin
            if (start_a) begin
                m_run  <= 1'b1;
                m_k    <= 0;
                m_err  <= 8'h00;
                m_ffv  <= 2'b00;
                m_ffm  <= 7'h00;
                m_bits <= 7'h00;
                m_pass <= 1'b0;
            end
        end else if (m_k < TotA) begin
            m_k    <= m_k + 1;
            m_hold <= 2'b11;
            if (m_k % (SA + 1) == SA) begin
                if (m_mm != 7'h00) begin
                    if (m_err != 8'hFF) m_err <= m_err + 8'd1;
                    if (m_err == 8'h00) begin
                        m_ffv <= exp_vec;
                        m_ffm <= m_mm;
                    end
                end
                m_bits <= m_bits | m_mm;
                if (m_k == TotA - 1) m_pass <= (m_err == 8'h00) && (m_mm == 7'h00);
            end
        end else begin
            m_run <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_a();
        chk("a_busy", 32'(busy_a), 32'(exp_busy));
        chk("a_done", 32'(done_a), 32'(exp_done));
        chk("a_vec", 32'({a_a, b_a}), 32'(exp_vec));
        chk("a_pass", 32'(pass_a), 32'(m_pass));
        chk("a_err_cnt", 32'(err_a), 32'(m_err));
        chk("a_ff_vec", 32'(ffv_a), 32'(m_ffv));
        chk("a_ff_mask", 32'(ffm_a), 32'(m_ffm));
`ifdef LGC_ERR_ACCUM_EN
        chk("a_err_bits", 32'(bits_a), 32'(m_bits));
`endif
    endtask

    // Drive at negedge, compare 1 time unit after the following posedge.
    task automatic cyc(input logic st);
        start_a = st;
        @(posedge clk);
        #1;
        compare_a();
        if (busy_a) busy_seen = busy_seen + 1;
        if (done_a) done_seen = done_seen + 1;
        @(negedge clk);
    endtask

    task automatic run_a(input int n);
        busy_seen = 0;
        done_seen = 0;
        cyc(1'b1);
        for (int i = 1; i < n; i++) cyc(1'b0);
    endtask

    task automatic cycb(input logic st);
        start_b = st;
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    initial begin
        int blen, gap, nd, nrun;
        logic seen;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        and_a   = 7'h7F;
        flip_a  = 7'h00;
        tie_b   = 1'b1;
        #2;
        chk("reset_a", 32'({a_a, b_a, busy_a, done_a, pass_a, err_a, ffv_a, ffm_a}), 32'd0);
        chk("reset_b", 32'({a_b, b_b, busy_b, done_b, pass_b, err_b, ffv_b, ffm_b}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0);

        // Clean run with default parameters.
        run_a(16);
        chk("clean_busy_len", 32'(busy_seen), 32'd12);
        chk("clean_done_cnt", 32'(done_seen), 32'd1);
        chk("clean_pass", 32'(pass_a), 32'd1);
        chk("clean_vec_end", 32'({a_a, b_a}), 32'd3);

        // XOR output stuck at 0.
        and_a = 7'h5F;
        run_a(16);
        chk("xor0_err_cnt", 32'(err_a), 32'd2);
        chk("xor0_ff_vec", 32'(ffv_a), 32'd1);
        chk("xor0_ff_mask", 32'(ffm_a), 32'h20);
        chk("xor0_pass", 32'(pass_a), 32'd0);
`ifdef LGC_ERR_ACCUM_EN
        chk("xor0_err_bits", 32'(bits_a), 32'h20);
`endif
        and_a = 7'h7F;

        // Start re-pulsed while the run is in progress.
        busy_seen = 0;
        done_seen = 0;
        cyc(1'b1);
        for (int i = 1; i < 14; i++) cyc(1'($urandom_range(0, 1)));
        for (int i = 14; i < 20; i++) cyc(1'b0);
        chk("restart_busy_len", 32'(busy_seen), 32'd12);
        chk("restart_done_cnt", 32'(done_seen), 32'd1);

        // Random starts and random corruption of y.
        for (int i = 0; i < 400; i++) begin
            flip_a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            cyc(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end
        flip_a = 7'h00;
        for (int i = 0; i < 16; i++) cyc(1'b0);

        // Reset during SETTLE of vector 10.
        run_a(7);
        chk("pre_rst_vec", 32'({a_a, b_a}), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_a", 32'({a_a, b_a, busy_a, done_a, pass_a, err_a, ffv_a, ffm_a}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) cyc(1'b0);
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        run_a(16);
        chk("post_rst_busy_len", 32'(busy_seen), 32'd12);
        chk("post_rst_pass", 32'(pass_a), 32'd1);

        // DUT B: LOOPS=100 with y tied low saturates the counter.
        tie_b = 1'b1;
        cycb(1'b1);
        seen = 1'b0;
        blen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            if (busy_b) blen = blen + 1;
            if (done_b) seen = 1'b1;
            else cycb(1'b0);
        end
        chk("sat_done_seen", 32'(seen), 32'd1);
        chk("sat_busy_len", 32'(blen), 32'd800);
        chk("sat_err_cnt", 32'(err_b), 32'hFF);
        chk("sat_ff_vec", 32'(ffv_b), 32'd0);
        chk("sat_ff_mask", 32'(ffm_b), 32'h5C);
        chk("sat_pass", 32'(pass_b), 32'd0);
        cycb(1'b0);

        // DUT B: start held high gives back-to-back runs.
        tie_b = 1'b0;
        nd = 0;
        nrun = 0;
        blen = 0;
        gap = 0;
        for (int i = 0; i < 1700; i++) begin
            cycb(1'b1);
            if (busy_b) begin
                if (blen == 0 && nrun > 0) chk("b2b_gap", 32'(gap), 32'd2);
                blen = blen + 1;
                gap = 0;
            end else begin
                if (blen != 0) begin
                    chk("b2b_busy_len", 32'(blen), 32'd800);
                    nrun = nrun + 1;
                end
                blen = 0;
                gap = gap + 1;
            end
            if (done_b) begin
                nd = nd + 1;
                chk("b2b_pass", 32'(pass_b), 32'd1);
                chk("b2b_err_cnt", 32'(err_b), 32'd0);
            end
        end
        chk("b2b_done_cnt", 32'(nd), 32'd2);
        start_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l_gates_checker.md
Name: l_gates_checker

Overview:
- Self-checking sequencer that sits directly upstream and downstream of the 2-input logic-gate block.
- Drives the gate inputs a/b through all four combinations, samples the 7-bit gate result bus, and compares it against a built-in golden truth table.
- Reports pass/fail, an error count and first-failure details over a start/busy/done handshake.
- Used for on-board bring-up of the gate block without a simulator.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling y_i; legal range >=1.
- LOOPS, 1, number of full passes over the 4 input vectors; legal range >=1.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled in IDLE only.
- a_o  output  1  drives gate input a.
- b_o  output  1  drives gate input b.
- y_i  input  7  gate result bus: [0]AND [1]OR [2]NOT a [3]NAND [4]NOR [5]XOR [6]XNOR.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  run result, held until the next accepted start.
- err_cnt  output  ERR_W  count of mismatching vectors; saturates at all-ones.
- first_fail_vec  output  2  {a,b} of the first mismatching vector.
- first_fail_mask  output  7  y_i XOR golden at the first mismatch.

Behaviour:
- Reset: all outputs 0 (a_o, b_o, busy, done, pass, err_cnt, first_fail_vec, first_fail_mask). FSM goes to IDLE; vector index and loop counters are cleared. Reset mid-run aborts immediately; no done pulse.
- Golden table, indexed by vec={a,b}:
  - 00 -> 7'h5C
  - 01 -> 7'h2E
  - 10 -> 7'h2A
  - 11 -> 7'h43
- Vector drive: {a_o,b_o} = vec, registered.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 -> SETTLE.
  - On the same edge: vec=0, loop=0, settle counter=SETTLE_CYCLES-1.
  - Clear err_cnt, first_fail_*, pass.
  - busy=1 from the next cycle.
- SETTLE:
  - Hold vec on a_o/b_o and decrement the counter.
  - At 0 -> CHECK.
  - The state occupies exactly SETTLE_CYCLES cycles.
- CHECK: one cycle. Compare y_i with golden[vec].
  - On mismatch: err_cnt+1 (saturating).
  - If this is the first mismatch of the run: capture first_fail_vec=vec and first_fail_mask=y_i^golden.
  - If vec==3 and loop==LOOPS-1 -> DONE.
  - Otherwise: vec wraps 3->0 with loop+1, or vec+1; reload the counter; -> SETTLE.
- DONE:
  - done=1 and busy=0 for one cycle.
  - pass = (err_cnt==0), including the final CHECK result.
  - Next state IDLE.
- Timing: busy is high for exactly 4*LOOPS*(SETTLE_CYCLES+1) cycles; done follows in the first cycle after busy falls.
- start handling: ignored in SETTLE, CHECK and DONE; a start held high re-triggers in IDLE the cycle after DONE.
- Results are held stable in IDLE until the next accepted start.
- a_o/b_o keep the last vector (11) after a run; they return to 00 only on start or reset.
- y_i is treated as synchronous to clk; no synchronizer is included.

Optional Feature:
- Macro: LGC_ERR_ACCUM_EN.
- Defined:
  - Adds output err_bits[6:0]: a sticky OR of y_i^golden over every CHECK in the run.
  - Cleared on accepted start and on reset.
  - Identifies stuck gate outputs across all vectors.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Correct gate model, defaults, start pulsed 1 cycle -> busy high exactly 12 cycles; a_o/b_o step 00,01,10,11; done pulses once; pass=1, err_cnt=0.
- y_i[5] forced 0 -> mismatches at vec 01 and 10; err_cnt=2, first_fail_vec=2'b01, first_fail_mask=7'h20, pass=0; with LGC_ERR_ACCUM_EN, err_bits=7'h20.
- LOOPS=100, y_i tied 7'h00 -> 400 mismatches; err_cnt saturates at 8'hFF, first_fail_vec=00, first_fail_mask=7'h5C, pass=0.
- start re-pulsed while busy -> ignored; run length is still 12 cycles with a single done pulse.
- rst asserted during SETTLE of vec 10 -> all outputs 0 asynchronously, no done pulse; a later start runs a full, correct sequence.
- SETTLE_CYCLES=1, start held high continuously -> back-to-back runs of 8 busy cycles each, separated by the DONE and IDLE cycles, each ending with pass=1.
